// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN,
    ST_FAULT
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Force a target onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry instruction/PC buffer facing decode, plus the pc_out+4 adder.
// clear_i wins over load_i so a redirect always flushes a same-cycle fill.
module fetch_out_buffer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Buffer register: flush to NOP, load a fetched word, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + PC_INC;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues req/ready fetches to instruction
// memory, applies execute redirects and feeds decode via a 1-entry buffer.
// A request is never aborted: a redirect while waiting parks the target in
// pending_pc and the FSM drains the old transaction first.
// Optional build macro FETCH_ALIGN_CHECK_EN adds fetch_fault and the FAULT
// state for misaligned redirect targets; without it low PC bits are masked.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_busy
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic         pend_fault_q, pend_fault_d;
  logic [31:0]  redir_tgt;
  logic         misaligned;
  logic         consume;
  logic         buf_load, buf_clear;
  fetch_state_e redir_state;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned  = redirect_valid & (|redirect_pc[1:0]);
  assign redir_tgt   = redirect_pc;
  assign fetch_fault = pend_fault_q | (state_q == ST_FAULT);
`else
  assign misaligned  = 1'b0;
  assign redir_tgt   = align_pc(redirect_pc);
`endif

  assign consume     = instr_valid & ~stall_i;
  assign redir_state = misaligned ? ST_FAULT : ST_FETCH;
  assign imem_req    = (state_q == ST_FETCH) | (state_q == ST_DRAIN);
  assign fetch_busy  = imem_req;
  assign imem_addr   = pc_q;

  // Buffer control: fill on a clean fetch completion, flush on redirect/consume.
  always_comb begin
    buf_load  = (state_q == ST_FETCH) & imem_ready & ~redirect_valid;
    buf_clear = redirect_valid | ((state_q == ST_HOLD) & consume);
  end

  // Next-state logic; priority is redirect > imem_ready > stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    pend_fault_d = pend_fault_q;
    case (state_q)
      ST_BOOT, ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = redir_state;
        end else if (state_q == ST_BOOT || consume) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          if (imem_ready) begin
            pc_d    = redir_tgt;
            state_d = redir_state;
          end else begin
            pending_pc_d = redir_tgt;
            pend_fault_d = misaligned;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ready) begin
          pc_d    = pc_q + PC_INC;
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // A parked fault target is sticky; otherwise the latest redirect wins.
        if (redirect_valid && !pend_fault_q) begin
          pending_pc_d = redir_tgt;
          pend_fault_d = misaligned;
        end
        if (imem_ready) begin
          pend_fault_d = 1'b0;
          if (pend_fault_q) begin
            pc_d    = pending_pc_q;
            state_d = ST_FAULT;
          end else if (redirect_valid) begin
            pc_d    = redir_tgt;
            state_d = redir_state;
          end else begin
            pc_d    = pending_pc_q;
            state_d = ST_FETCH;
          end
        end
      end
      default: ;  // ST_FAULT: frozen until reset
    endcase
  end

  // FSM, PC and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'h0;
      pend_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      pend_fault_q <= pend_fault_d;
    end
  end

  fetch_out_buffer #(
    .NOP_WORD(NOP_WORD)
  ) u_obuf (
    .clk          (clk),
    .rst_n        (reset),
    .load_i       (buf_load),
    .clear_i      (buf_clear),
    .instr_i      (imem_rdata),
    .pc_i         (pc_q),
    .instr_valid_o(instr_valid),
    .instr_o      (instr_out),
    .pc_o         (pc_out),
    .pc_plus4_o   (pc_plus4_out)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Memory returns addr ^ MAGIC whenever
// the bench raises mem_ready; expected values are hand-computed constants.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP   = 32'hA000_0000;
  localparam logic [31:0] MAGIC = 32'h1234_5600;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        fetch_busy;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ MAGIC;

  fetch_sequencer #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(mem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .fetch_busy(fetch_busy)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the fetch-side view: req, addr (when requesting) and busy.
  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".busy"}, {31'b0, fetch_busy}, {31'b0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  // Check the decode-side view of the buffer.
  task automatic chk_buf(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({tag, ".instr"}, instr_out, ins);
    if (v) begin
      chk({tag, ".pc"}, pc_out, pc);
      chk({tag, ".pc4"}, pc_plus4_out, pc + 32'd4);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_req("rst", 1'b0, 32'h0);
    chk_buf("rst", 1'b0, NOP, 32'h0);
    chk("rst.pc_out", pc_out, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    reset = 1'b1;
    mem_ready = 1'b1;
    chk_req("boot", 1'b0, 32'h0);

    // Zero-wait streaming: one instruction every two cycles
    tick(); chk_req("f0", 1'b1, 32'h0);  chk_buf("f0", 1'b0, NOP, 32'h0);
    tick(); chk_req("h0", 1'b0, 32'h0);  chk_buf("h0", 1'b1, 32'h1234_5600, 32'h0);
    tick(); chk_req("f4", 1'b1, 32'h4);  chk_buf("f4", 1'b0, NOP, 32'h0);
    tick(); chk_req("h4", 1'b0, 32'h0);  chk_buf("h4", 1'b1, 32'h1234_5604, 32'h4);
    tick(); chk_req("f8", 1'b1, 32'h8);
    tick(); chk_buf("h8", 1'b1, 32'h1234_5608, 32'h8);

    // Stall holds the buffer and issues no request
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_req("stall", 1'b0, 32'h0);
      chk_buf("stall", 1'b1, 32'h1234_5608, 32'h8);
    end
    stall_i = 1'b0;
    tick(); chk_req("fC", 1'b1, 32'hC); chk_buf("fC", 1'b0, NOP, 32'h0);

    // Slow memory: request held three cycles at a stable address
    mem_ready = 1'b0;
    tick(); chk_req("wait1", 1'b1, 32'hC); chk_buf("wait1", 1'b0, NOP, 32'h0);
    tick(); chk_req("wait2", 1'b1, 32'hC);
    mem_ready = 1'b1;
    tick(); chk_req("hC", 1'b0, 32'h0); chk_buf("hC", 1'b1, 32'h1234_560C, 32'hC);
    tick(); chk_req("f10", 1'b1, 32'h10); chk_buf("f10", 1'b0, NOP, 32'h0);

    // Redirect while waiting: drain old request, then fetch the target
    mem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); redirect_valid = 1'b0;
    chk_req("drain1", 1'b1, 32'h10); chk_buf("drain1", 1'b0, NOP, 32'h0);
    tick(); chk_req("drain2", 1'b1, 32'h10);
    mem_ready = 1'b1;
    tick(); chk_req("f100", 1'b1, 32'h100); chk_buf("f100", 1'b0, NOP, 32'h0);

    // Latest redirect wins, same-cycle redirect beats pending target
    mem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    tick(); chk_req("drainA", 1'b1, 32'h100);
    redirect_pc = 32'h200;
    tick(); chk_req("drainB", 1'b1, 32'h100); chk_buf("drainB", 1'b0, NOP, 32'h0);
    redirect_pc = 32'h300; mem_ready = 1'b1;
    tick(); redirect_valid = 1'b0;
    chk_req("f300", 1'b1, 32'h300); chk_buf("f300", 1'b0, NOP, 32'h0);
    tick(); chk_buf("h300", 1'b1, 32'h1234_5500, 32'h300);

`ifndef FETCH_ALIGN_CHECK_EN
    // Redirect from HOLD with low bits set: masked to a word address
    redirect_valid = 1'b1; redirect_pc = 32'h402;
    tick(); chk_req("f400", 1'b1, 32'h400); chk_buf("f400", 1'b0, NOP, 32'h0);
`else
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick(); chk_req("f400", 1'b1, 32'h400); chk_buf("f400", 1'b0, NOP, 32'h0);
`endif
    // Redirect in FETCH with ready: fetched word discarded
    redirect_pc = 32'h500;
    tick(); redirect_valid = 1'b0;
    chk_req("f500", 1'b1, 32'h500); chk_buf("f500", 1'b0, NOP, 32'h0);
    tick(); chk_buf("h500", 1'b1, 32'h1234_5300, 32'h500);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;
    chk_req("fTop", 1'b1, 32'hFFFF_FFFC);
    tick(); chk_buf("hTop", 1'b1, 32'hEDCB_A9FC, 32'hFFFF_FFFC);
    chk("hTop.pc4wrap", pc_plus4_out, 32'h0);
    tick(); chk_req("fWrap", 1'b1, 32'h0);

    // Reset asserted in the middle of a drain
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); chk_req("f40", 1'b1, 32'h40);
    mem_ready = 1'b0; redirect_pc = 32'h80;
    tick(); redirect_valid = 1'b0;
    chk_req("drain40", 1'b1, 32'h40);
    reset = 1'b0;
    #1;
    chk_req("rstMid", 1'b0, 32'h0);
    chk("rstMid.addr", imem_addr, 32'h0);
    chk_buf("rstMid", 1'b0, NOP, 32'h0);
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    tick(); chk_req("reboot", 1'b1, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect: fault, no further requests until reset
    chk("flt.pre", {31'b0, fetch_fault}, 32'h0);
    mem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick(); redirect_valid = 1'b0;
    chk("flt.set", {31'b0, fetch_fault}, 32'h1);
    chk_req("flt.drain", 1'b1, 32'h0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("flt", 1'b0, 32'h0);
      chk("flt.hold", {31'b0, fetch_fault}, 32'h1);
      chk_buf("flt", 1'b0, NOP, 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
